// File: rtl/ext_irq_ctrl.sv
// ----------------------------------------------------------------------------
// ext_irq_ctrl
//
// External interrupt controller feeding the core's irq_req/irq_id pair.
// Peripheral lines are registered once, masked by a software enable register,
// and the lowest-index candidate is offered to the core as a single request.
// The request is held until the core acknowledges trap entry; the source then
// stays claimed (ACTIVE) until software writes its id to CLAIM/COMPLETE.
//
// Build option:
//   EXT_IRQ_EDGE_EN  undefined -> level mode, pending mirrors the registered lines
//                    defined   -> edge mode, rising edges are latched in pending
//                                 until the core acknowledges that source
//
// Ports:
//   clk          core clock
//   rst          synchronous reset, active-high
//   src_i        peripheral interrupt lines (synchronous to clk)
//   irq_req_o    interrupt request to the core
//   irq_id_o     id of the requested source, valid while irq_req_o=1
//   irq_ack_i    1-cycle pulse from the core when it takes the trap
//   reg_we_i     config write strobe
//   reg_re_i     config read strobe
//   reg_addr_i   byte address: 0x0 ENABLE, 0x4 PENDING (RO), 0x8 CLAIM/COMPLETE
//   reg_wdata_i  config write data
//   reg_rdata_o  config read data, one cycle after reg_re_i, held otherwise
// ----------------------------------------------------------------------------
module ext_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    output logic               irq_req_o,
    output logic [7:0]         irq_id_o,
    input  logic               irq_ack_i,
    input  logic               reg_we_i,
    input  logic               reg_re_i,
    input  logic [3:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] ADDR_ENABLE   = 4'h0;
    localparam logic [3:0] ADDR_PENDING  = 4'h4;
    localparam logic [3:0] ADDR_CLAIM    = 4'h8;

    state_t             state_q, state_d;
    logic [7:0]         id_q, id_d;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] id_mask;
    logic               id_in_cand;
    logic               complete_hit;

    // Not every write-data bit is meaningful for every register.
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata_i;

    // Lowest set index wins; scanning downward lets the last hit be the lowest.
    function automatic logic [7:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        lowest_idx = 8'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = 8'(i);
        end
    endfunction

    // ---- input stage: one register on the peripheral lines ----
    always_ff @(posedge clk) begin
        if (rst) src_q <= '0;
        else     src_q <= src_i;
    end

    // ---- pending generation ----
`ifdef EXT_IRQ_EDGE_EN
    logic [NUM_SRC-1:0] src_q_d;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_clr;

    assign rise    = src_q & ~src_q_d;
    assign ack_clr = (state_q == REQ && irq_ack_i) ? id_mask : '0;

    // A new edge in the same cycle as the ack clear must not be lost, so the
    // set term is ORed in after the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q_d   <= '0;
            pending_q <= '0;
        end else begin
            src_q_d   <= src_q;
            pending_q <= (pending_q & ~ack_clr) | rise;
        end
    end

    assign pending = pending_q;
`else
    assign pending = src_q;
`endif

    assign cand         = pending & enable_q;
    // Shift rather than bit-select so an 8-bit id can address any NUM_SRC.
    assign id_mask      = NUM_SRC'(1) << id_q;
    assign id_in_cand   = |(cand & id_mask);
    assign complete_hit = reg_we_i && (reg_addr_i == ADDR_CLAIM) &&
                          (reg_wdata_i[7:0] == id_q);

    // ---- enable register ----
    always_ff @(posedge clk) begin
        if (rst) enable_q <= '0;
        else if (reg_we_i && reg_addr_i == ADDR_ENABLE)
            enable_q <= reg_wdata_i[NUM_SRC-1:0];
    end

    // ---- request FSM ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d = REQ;
                    id_d    = lowest_idx(cand);
                end
            end
            REQ: begin
                // Ack beats withdraw; a withdrawn request returns to IDLE and
                // only re-arbitrates on the following cycle.
                if (irq_ack_i)        state_d = ACTIVE;
                else if (!id_in_cand) state_d = IDLE;
            end
            ACTIVE: begin
                if (complete_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign irq_req_o = (state_q == REQ);
    assign irq_id_o  = id_q;

    // ---- register read port (sampled before any same-cycle write lands) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_rdata_o <= 32'd0;
        end else if (reg_re_i) begin
            case (reg_addr_i)
                ADDR_ENABLE:  reg_rdata_o <= 32'(enable_q);
                ADDR_PENDING: reg_rdata_o <= 32'(pending);
                ADDR_CLAIM:   reg_rdata_o <= {(state_q == ACTIVE), 23'd0, id_q};
                default:      reg_rdata_o <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
`timescale 1ns/1ps
module tb_ext_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  src_i;
    logic        irq_req_o;
    logic [7:0]  irq_id_o;
    logic        irq_ack_i;
    logic        reg_we_i;
    logic        reg_re_i;
    logic [3:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;

    int n_checks = 0;
    int n_fail   = 0;

    ext_irq_ctrl #(.NUM_SRC(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_i       (src_i),
        .irq_req_o   (irq_req_o),
        .irq_id_o    (irq_id_o),
        .irq_ack_i   (irq_ack_i),
        .reg_we_i    (reg_we_i),
        .reg_re_i    (reg_re_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_rdata_o (reg_rdata_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and samples happen 1 ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
        reg_we_i    = 1'b1;
        reg_addr_i  = addr;
        reg_wdata_i = data;
        tick();
        reg_we_i    = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] addr, output logic [31:0] data);
        reg_re_i   = 1'b1;
        reg_addr_i = addr;
        tick();
        reg_re_i   = 1'b0;
        data       = reg_rdata_o;
    endtask

    task automatic ack();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        rst = 1'b1; src_i = 8'h00; irq_ack_i = 1'b0;
        reg_we_i = 1'b0; reg_re_i = 1'b0; reg_addr_i = 4'h0; reg_wdata_i = 32'h0;
        tick(2);
        check_eq("rst_req",   {31'd0, irq_req_o}, 32'd0);
        check_eq("rst_id",    {24'd0, irq_id_o},  32'd0);
        check_eq("rst_rdata", reg_rdata_o,        32'd0);
        rst = 1'b0;
        tick();

`ifndef EXT_IRQ_EDGE_EN
        // 1: enable=0x05, src=0x04 -> id 2 two edges later, held until ack
        reg_write(4'h0, 32'h0000_0005);
        src_i = 8'h04;
        tick();
        check_eq("t1_not_yet", {31'd0, irq_req_o}, 32'd0);
        tick();
        check_eq("t1_req", {31'd0, irq_req_o}, 32'd1);
        check_eq("t1_id",  {24'd0, irq_id_o},  32'd2);
        tick(3);
        check_eq("t1_hold_req", {31'd0, irq_req_o}, 32'd1);
        check_eq("t1_hold_id",  {24'd0, irq_id_o},  32'd2);
        ack();
        check_eq("t1_ack_drop", {31'd0, irq_req_o}, 32'd0);
        reg_read(4'h8, rd);
        check_eq("t1_claim_rd", rd, 32'h8000_0002);
        reg_read(4'h0, rd);
        check_eq("t1_enable_rd", rd, 32'h0000_0005);
        reg_read(4'h4, rd);
        check_eq("t1_pending_rd", rd, 32'h0000_0004);
        reg_read(4'hC, rd);
        check_eq("t1_other_rd", rd, 32'h0);
        irq_ack_i = 1'b1;   // ack outside REQ has no effect
        tick();
        irq_ack_i = 1'b0;
        reg_read(4'h8, rd);
        check_eq("t1_stray_ack", rd, 32'h8000_0002);

        // Level still high after complete re-requests
        reg_write(4'h8, 32'h0000_0002);
        check_eq("lvl_after_cpl", {31'd0, irq_req_o}, 32'd0);
        tick();
        check_eq("lvl_rereq", {31'd0, irq_req_o}, 32'd1);
        // Line drops while in REQ -> withdrawn without ack
        src_i = 8'h00;
        tick();
        check_eq("lvl_drop_lag", {31'd0, irq_req_o}, 32'd1);
        tick();
        check_eq("lvl_withdraw", {31'd0, irq_req_o}, 32'd0);

        // 2: src=0x0C, enable=0xFF -> id 2 wins, re-requests after complete
        reg_write(4'h0, 32'h0000_00FF);
        src_i = 8'h0C;
        tick(2);
        check_eq("t2_req", {31'd0, irq_req_o}, 32'd1);
        check_eq("t2_id",  {24'd0, irq_id_o},  32'd2);
        ack();
        reg_write(4'h8, 32'h0000_0002);
        tick();
        check_eq("t2_rereq_id", {23'd0, irq_req_o, irq_id_o}, 32'h102);
        ack();
        src_i = 8'h08;
        tick();
        reg_write(4'h8, 32'h0000_0002);
        tick();
        check_eq("t2_next_id", {23'd0, irq_req_o, irq_id_o}, 32'h103);

        // 3: disable in REQ id 3 -> back to IDLE, no ack
        reg_write(4'h0, 32'h0000_0000);
        tick();
        check_eq("t3_withdraw", {31'd0, irq_req_o}, 32'd0);
        reg_read(4'h8, rd);
        check_eq("t3_not_active", rd, 32'h0000_0003);
        reg_write(4'h0, 32'h0000_0008);
        tick();
        check_eq("t3_idle_rereq", {23'd0, irq_req_o, irq_id_o}, 32'h103);

        // 4: ACTIVE id 1, mismatched complete ignored, matching one releases
        src_i = 8'h0A;
        ack();
        reg_write(4'h0, 32'h0000_00FF);
        reg_write(4'h8, 32'h0000_0003);
        tick();
        check_eq("t4_req_id1", {23'd0, irq_req_o, irq_id_o}, 32'h101);
        ack();
        src_i = 8'h08;
        reg_write(4'h8, 32'h0000_0005);
        tick(2);
        check_eq("t4_bad_cpl_noreq", {31'd0, irq_req_o}, 32'd0);
        reg_read(4'h8, rd);
        check_eq("t4_still_active", rd, 32'h8000_0001);
        reg_write(4'h4, 32'h0000_00FF);   // read-only, ignored
        reg_read(4'h4, rd);
        check_eq("t4_pending_ro", rd, 32'h0000_0008);
        reg_write(4'h8, 32'h0000_0001);
        tick();
        check_eq("t4_next_src", {23'd0, irq_req_o, irq_id_o}, 32'h103);

        // Simultaneous read and write of ENABLE returns the old value
        reg_we_i = 1'b1; reg_re_i = 1'b1; reg_addr_i = 4'h0; reg_wdata_i = 32'hFFFF_FF33;
        tick();
        reg_we_i = 1'b0; reg_re_i = 1'b0;
        check_eq("rw_same_addr", reg_rdata_o, 32'h0000_00FF);
        reg_read(4'h0, rd);
        check_eq("enable_upper_ignored", rd, 32'h0000_0033);
        reg_write(4'h0, 32'h0000_00FF);
        tick();
        check_eq("pre_rst_req", {31'd0, irq_req_o}, 32'd1);
`else
        // 5: edge captured while disabled, then requested once enabled
        src_i = 8'h40;
        tick();
        src_i = 8'h00;
        tick(2);
        check_eq("t5_no_req_dis", {31'd0, irq_req_o}, 32'd0);
        reg_read(4'h4, rd);
        check_eq("t5_pending", rd, 32'h0000_0040);
        reg_write(4'h0, 32'h0000_0040);
        tick();
        check_eq("t5_req_id6", {23'd0, irq_req_o, irq_id_o}, 32'h106);
        ack();
        check_eq("t5_ack_drop", {31'd0, irq_req_o}, 32'd0);
        reg_read(4'h4, rd);
        check_eq("t5_pending_clr", rd, 32'h0);
        reg_read(4'h8, rd);
        check_eq("t5_active", rd, 32'h8000_0006);
        // A steady high line gives only one edge
        reg_write(4'h8, 32'h0000_0006);
        src_i = 8'h40;
        tick(3);
        check_eq("t5_second_edge", {23'd0, irq_req_o, irq_id_o}, 32'h106);
        ack();
        reg_write(4'h8, 32'h0000_0006);
        tick(2);
        check_eq("t5_level_no_rereq", {31'd0, irq_req_o}, 32'd0);
        // Set up a request for the reset test
        src_i = 8'h00;
        reg_write(4'h0, 32'h0000_00FF);
        src_i = 8'h02;
        tick(3);
        check_eq("pre_rst_req", {23'd0, irq_req_o, irq_id_o}, 32'h101);
`endif

        // 6: reset during REQ
        src_i = 8'h00;
        rst   = 1'b1;
        tick();
        check_eq("t6_rst_req", {31'd0, irq_req_o}, 32'd0);
        check_eq("t6_rst_id",  {24'd0, irq_id_o},  32'd0);
        rst = 1'b0;
        reg_read(4'h0, rd);
        check_eq("t6_enable", rd, 32'h0);
        reg_read(4'h4, rd);
        check_eq("t6_pending", rd, 32'h0);
        src_i = 8'hFF;
        tick(4);
        check_eq("t6_no_req", {31'd0, irq_req_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
